busready: RTL
=============

Name: busReadY

Overview:
- Read-side counterpart to the Y-memory write path. Accepts single-entry read requests, each an 11-bit row address plus a 4-bit one-hot slot select.
- Fetches the 256-bit Y row, extracts the 48-bit {real,img} entry and returns it over a valid/ready response channel.
- Keeps a one-row cache so repeated requests to the same row skip the memory read. The cache is invalidated by the writer's write strobe.

Parameters:
- RD_LAT, 1, Y memory read latency in clock edges from the edge that samples mem_RE high to valid mem_readData.
- CNT_W, 16, width of the saturating hit counter.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (combinational, high only in IDLE)
- req_addr  in  11  Y row address
- req_oh  in  4  one-hot slot select
- inv_en  in  1  writer write strobe (writer WE bit)
- inv_addr  in  11  writer write address
- mem_RE  out  1  Y memory read enable, registered
- mem_readAddr  out  11  Y memory read address, registered
- mem_readData  in  256  Y memory read row
- rsp_valid  out  1  response valid, registered
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  48  extracted entry
- rsp_addr  out  11  echo of the request row address
- rsp_err  out  1  req_oh was not one-hot
- hit_count  out  CNT_W  saturating count of cache hits

Behaviour:
- Reset (async, immediate):
  - state=IDLE, mem_RE=0, mem_readAddr=11'h7ff.
  - rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_err=0.
  - cache_valid=0, cached_addr=0, cached_row=0, hit_count=0, latency counter=0.
  - Any in-flight request is dropped. The block emits no response for it.
- Slot map:
  - 0001 -> row[47:0]
  - 0010 -> row[111:64]
  - 0100 -> row[175:128]
  - 1000 -> row[239:192]
  - Bits [63:48], [127:112], [191:176] and [255:240] are never returned.
- State machine: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. Acceptance occurs on the edge where req_valid=1.
  - Not one-hot (0000 or multi-hot): go to RESP with rsp_data=0, rsp_err=1, rsp_addr=req_addr. No memory read. Cache untouched.
  - Hit (cache_valid and req_addr==cached_addr): go to RESP with slot extracted from cached_row and rsp_err=0. hit_count increments, saturating at all-ones. Latency: rsp_valid high 1 cycle after the accept edge.
  - Miss: mem_RE<=1 and mem_readAddr<=req_addr for exactly one cycle. Latch the address and OH, load the counter with RD_LAT, go to WAIT.
  - WAIT: mem_RE=0 and mem_readAddr=11'h7ff. The counter decrements once per edge after RE is sampled. When the data edge is reached, capture mem_readData, extract the slot, load cached_row/cached_addr, set cache_valid, and go to RESP. With RD_LAT=1, rsp_valid rises 3 edges after the accept edge.
  - RESP: rsp_valid=1, and rsp_data/rsp_addr/rsp_err are held stable until rsp_ready=1. On the edge where rsp_ready=1, rsp_valid<=0 and state returns to IDLE. There is no same-cycle re-accept; req_ready rises the next cycle.
- Invalidation:
  - inv_en=1 with inv_addr==cached_addr clears cache_valid on that edge, in any state.
  - If inv_en matches the latched miss address at any point during WAIT, including the capture edge, the row is still returned but cache_valid stays 0 after capture.
  - Invalidation and a hit acceptance on the same edge with the same address: the invalidate wins. The request is treated as a miss.
- req_addr and req_oh are sampled only at acceptance. Changes at other times are ignored.
- rsp_ready while rsp_valid=0 is ignored.

Test Plan:
1. Reset, then request addr=0x012, oh=0100, with memory row[175:128]=48'hABCDEF123456 and RD_LAT=1 -> mem_RE pulses 1 cycle with mem_readAddr=0x012. rsp_valid rises 3 edges after accept, rsp_data=48'hABCDEF123456, rsp_err=0.
2. Follow with addr=0x012, oh=0001 and rsp_ready tied high -> no mem_RE. rsp_valid 1 cycle after accept with row[47:0]. hit_count=1.
3. inv_en=1, inv_addr=0x012 in IDLE, then request 0x012/0010 -> treated as a miss: mem_RE asserted, hit_count unchanged.
4. Request with oh=0110 -> no mem_RE, rsp_data=0, rsp_err=1, rsp_addr echoed. Hold rsp_ready=0 for 5 cycles -> outputs stable and req_ready=0 throughout.
5. Miss to 0x3FF, assert reset during WAIT -> all outputs at reset values immediately. No response after release. The next request to 0x3FF misses.
6. Miss to 0x020 with inv_en/inv_addr=0x020 during WAIT -> correct data returned. An immediate re-request of 0x020 misses (mem_RE pulses again).

Source files
------------

// File: rtl/busready.sv
// Y-memory read path: single-entry requests, slot extraction from a 256-bit row,
// one-row cache invalidated by the writer's strobe, valid/ready response channel.
module busready #(
   parameter int RD_LAT = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [10:0]       req_addr,
   input  logic [3:0]        req_oh,
   input  logic              inv_en,
   input  logic [10:0]       inv_addr,
   output logic              mem_RE,
   output logic [10:0]       mem_readAddr,
   input  logic [255:0]      mem_readData,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [47:0]       rsp_data,
   output logic [10:0]       rsp_addr,
   output logic              rsp_err,
   output logic [CNT_W-1:0]  hit_count
);

   // state | meaning
   // IDLE  | ready for a request; decide error / hit / miss on accept
   // WAIT  | memory read in flight; capture row at terminal count
   // RESP  | response held on rsp_* until rsp_ready
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam int LAT_W = $clog2(RD_LAT + 2);

   state_t             r_state, w_next;
   logic [LAT_W-1:0]   r_cnt;
   logic               r_cache_valid;
   logic [10:0]        r_cached_addr;
   logic [191:0]       r_cached_row;
   logic [10:0]        r_lat_addr;
   logic [3:0]         r_lat_oh;
   logic               r_inv_seen;

   logic               w_onehot, w_inv_cache, w_inv_lat, w_hit, w_cap;
   logic [191:0]       w_rd_slots;
   logic               w_unused;

   // Only the four 48-bit entries are ever returned; the padding bits are dropped.
   assign w_rd_slots = {mem_readData[239:192], mem_readData[175:128],
                        mem_readData[111:64],  mem_readData[47:0]};
   assign w_unused   = ^{mem_readData[255:240], mem_readData[191:176],
                         mem_readData[127:112], mem_readData[63:48]};

   function automatic logic [47:0] f_slot(input logic [191:0] slots, input logic [3:0] oh);
      case (oh)
         4'b0001: f_slot = slots[47:0];
         4'b0010: f_slot = slots[95:48];
         4'b0100: f_slot = slots[143:96];
         4'b1000: f_slot = slots[191:144];
         default: f_slot = '0;
      endcase
   endfunction

   assign w_onehot    = (req_oh != 4'd0) && ((req_oh & (req_oh - 4'd1)) == 4'd0);
   assign w_inv_cache = inv_en && (inv_addr == r_cached_addr);
   assign w_inv_lat   = inv_en && (inv_addr == r_lat_addr);
   // A same-edge invalidate beats a hit, so the request falls through to a miss.
   assign w_hit       = r_cache_valid && (req_addr == r_cached_addr) && !w_inv_cache;
   assign w_cap       = (r_state == WAIT) && !mem_RE && (r_cnt == '0);
   assign req_ready   = (r_state == IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (req_valid) w_next = (!w_onehot || w_hit) ? RESP : WAIT;
         WAIT: if (w_cap)     w_next = RESP;
         RESP: if (rsp_ready) w_next = IDLE;
         default:             w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_RE        <= 1'b0;
         mem_readAddr  <= 11'h7ff;
         rsp_valid     <= 1'b0;
         rsp_data      <= '0;
         rsp_addr      <= '0;
         rsp_err       <= 1'b0;
         hit_count     <= '0;
         r_cnt         <= '0;
         r_cache_valid <= 1'b0;
         r_cached_addr <= '0;
         r_cached_row  <= '0;
         r_lat_addr    <= '0;
         r_lat_oh      <= '0;
         r_inv_seen    <= 1'b0;
      end else begin
         mem_RE       <= 1'b0;
         mem_readAddr <= 11'h7ff;
         if (w_inv_cache) r_cache_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  if (!w_onehot) begin
                     rsp_valid <= 1'b1;
                     rsp_data  <= '0;
                     rsp_err   <= 1'b1;
                     rsp_addr  <= req_addr;
                  end else if (w_hit) begin
                     rsp_valid <= 1'b1;
                     rsp_data  <= f_slot(r_cached_row, req_oh);
                     rsp_err   <= 1'b0;
                     rsp_addr  <= req_addr;
                     if (hit_count != {CNT_W{1'b1}}) hit_count <= hit_count + 1'b1;
                  end else begin
                     mem_RE       <= 1'b1;
                     mem_readAddr <= req_addr;
                     r_lat_addr   <= req_addr;
                     r_lat_oh     <= req_oh;
                     r_cnt        <= LAT_W'(RD_LAT);
                     r_inv_seen   <= 1'b0;
                  end
               end
            end
            WAIT: begin
               if (w_inv_lat) r_inv_seen <= 1'b1;
               // The edge that samples mem_RE does not count toward the latency.
               if (w_cap) begin
                  r_cached_row  <= w_rd_slots;
                  r_cached_addr <= r_lat_addr;
                  r_cache_valid <= !(r_inv_seen || w_inv_lat);
                  rsp_valid     <= 1'b1;
                  rsp_data      <= f_slot(w_rd_slots, r_lat_oh);
                  rsp_err       <= 1'b0;
                  rsp_addr      <= r_lat_addr;
               end else if (!mem_RE) begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            RESP: if (rsp_ready) rsp_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule
